// File: rtl/bht_pkg.sv
// -----------------------------------------------------------------------------
// bht_pkg -- shared types for the bht_sweep branch history table.
//   bht_entry_t  : one predictor entry {valid, 2-bit saturating counter}
//   bht_state_e  : sweep controller states {CLEAR, RUN}
//   CLEAR_ENTRY  : value written to every entry by the initialisation sweep
//   bht_next()   : entry update rule for one resolved branch
// -----------------------------------------------------------------------------
package bht_pkg;

    typedef struct packed {
        logic       valid;
        logic [1:0] counter;
    } bht_entry_t;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } bht_state_e;

    localparam bht_entry_t CLEAR_ENTRY = '{valid: 1'b0, counter: 2'b01};

    // First sighting seeds the counter weakly toward the observed direction;
    // afterwards the counter moves one step and saturates at 0 and 3.
    function automatic bht_entry_t bht_next(input bht_entry_t cur, input logic taken);
        bht_entry_t nxt;
        nxt.valid = 1'b1;
        if (!cur.valid) begin
            nxt.counter = taken ? 2'b10 : 2'b01;
        end else if (taken) begin
            nxt.counter = (cur.counter == 2'b11) ? 2'b11 : cur.counter + 2'd1;
        end else begin
            nxt.counter = (cur.counter == 2'b00) ? 2'b00 : cur.counter - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bht_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// bht_sweep_ctrl -- initialisation sweep FSM for the branch history table.
// After reset or a flush it walks a row pointer from 0 to ROWS-1, requesting
// one row clear per cycle, then enters RUN and raises ready.
// Ports:
//   clk_i       in   core clock
//   rst_i       in   synchronous active-high reset (restarts the sweep)
//   flush_bp_i  in   restart the sweep (from RUN or mid-sweep)
//   clear_we    out  clear the row addressed by clear_row this cycle
//   clear_row   out  row being cleared
//   ready       out  sweep finished, array usable
// -----------------------------------------------------------------------------
module bht_sweep_ctrl
    import bht_pkg::*;
#(
    parameter int ROWS     = 64,
    parameter int IDX_BITS = $clog2(ROWS)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_bp_i,
    output logic                clear_we,
    output logic [IDX_BITS-1:0] clear_row,
    output logic                ready
);

    bht_state_e          state_q, state_d;
    logic [IDX_BITS-1:0] ptr_q, ptr_d;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of process ordering.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // NOTE: every output of this block is defaulted first so no path leaves a
    // signal unassigned (which would infer a latch).
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        clear_we = 1'b0;
        ready    = 1'b0;
        unique case (state_q)
            CLEAR: begin
                clear_we = 1'b1;
                if (flush_bp_i) begin
                    ptr_d = '0;
                end else if (ptr_q == IDX_BITS'(ROWS - 1)) begin
                    state_d = RUN;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            RUN: begin
                ready = 1'b1;
                if (flush_bp_i) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    assign clear_row = ptr_q;

endmodule

// File: rtl/bht_sweep.sv
// -----------------------------------------------------------------------------
// bht_sweep -- branch history table with 2-bit saturating counters and a
// one-row-per-cycle initialisation sweep instead of an array reset.
// Optional feature: define BHT_UPDATE_BYPASS_EN to forward a same-cycle
// accepted update into the lookup outputs when row and column match vpc_i.
// Requires INSTR_PER_FETCH >= 2 and NR_ENTRIES/INSTR_PER_FETCH >= 2.
// Ports:
//   clk_i           in   core clock
//   rst_i           in   synchronous active-high reset
//   flush_bp_i      in   clear all predictor state (restarts the sweep)
//   debug_mode_i    in   suppress updates while high
//   vpc_i           in   fetch-block PC for lookup
//   update_valid_i  in   resolved-branch update strobe
//   update_pc_i     in   PC of the resolved branch
//   update_taken_i  in   resolved direction
//   pred_valid_o    out  per-slot entry valid (zero while sweeping)
//   pred_taken_o    out  per-slot predicted taken (zero while sweeping)
//   ready_o         out  array initialised and usable
// -----------------------------------------------------------------------------
module bht_sweep
    import bht_pkg::*;
#(
    parameter int NR_ENTRIES      = 128,
    parameter int INSTR_PER_FETCH = 2,
    parameter int VLEN            = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_bp_i,
    input  logic                       debug_mode_i,
    input  logic [VLEN-1:0]            vpc_i,
    input  logic                       update_valid_i,
    input  logic [VLEN-1:0]            update_pc_i,
    input  logic                       update_taken_i,
    output logic [INSTR_PER_FETCH-1:0] pred_valid_o,
    output logic [INSTR_PER_FETCH-1:0] pred_taken_o,
    output logic                       ready_o
);

    localparam int ROWS     = NR_ENTRIES / INSTR_PER_FETCH;
    localparam int COL_BITS = $clog2(INSTR_PER_FETCH);
    localparam int IDX_BITS = $clog2(ROWS);
    localparam int PC_LSB   = 1 + COL_BITS + IDX_BITS;

    logic                clear_we;
    logic [IDX_BITS-1:0] clear_row;
    logic                ready;

    bht_sweep_ctrl #(
        .ROWS     (ROWS),
        .IDX_BITS (IDX_BITS)
    ) u_ctrl (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .flush_bp_i (flush_bp_i),
        .clear_we   (clear_we),
        .clear_row  (clear_row),
        .ready      (ready)
    );

    bht_entry_t entry_q [ROWS][INSTR_PER_FETCH];

    logic [IDX_BITS-1:0] upd_row, rd_row;
    logic [COL_BITS-1:0] upd_col;
    logic                upd_en;
    bht_entry_t          upd_entry;

    assign upd_row = update_pc_i[1+COL_BITS +: IDX_BITS];
    assign upd_col = update_pc_i[1 +: COL_BITS];
    assign rd_row  = vpc_i[1+COL_BITS +: IDX_BITS];

    // Updates coinciding with reset or flush are dropped so the sweep starts
    // from a clean array.
    assign upd_en    = update_valid_i && !debug_mode_i && ready && !flush_bp_i && !rst_i;
    assign upd_entry = bht_next(entry_q[upd_row][upd_col], update_taken_i);

    // NOTE: the array has no reset; the sweep is what initialises it, keeping
    // the storage free of reset fan-out.
    always_ff @(posedge clk_i) begin
        if (clear_we) begin
            for (int c = 0; c < INSTR_PER_FETCH; c++) begin
                entry_q[clear_row][c] <= CLEAR_ENTRY;
            end
        end else if (upd_en) begin
            entry_q[upd_row][upd_col] <= upd_entry;
        end
    end

    always_comb begin
        bht_entry_t ent;
        pred_valid_o = '0;
        pred_taken_o = '0;
        for (int c = 0; c < INSTR_PER_FETCH; c++) begin
            ent = entry_q[rd_row][c];
`ifdef BHT_UPDATE_BYPASS_EN
            if (upd_en && (upd_row == rd_row) && (upd_col == COL_BITS'(c))) begin
                ent = upd_entry;
            end
`endif
            pred_valid_o[c] = ready && ent.valid;
            pred_taken_o[c] = ready && ent.counter[1];
        end
    end

    assign ready_o = ready;

    // Low PC bits inside the instruction and high bits above the index are
    // deliberately ignored (aliasing is accepted).
    logic unused_pc_bits;
    assign unused_pc_bits = ^{vpc_i[VLEN-1:PC_LSB], vpc_i[0],
                              update_pc_i[VLEN-1:PC_LSB], update_pc_i[0]};

endmodule

// File: doc/bht_sweep.md
BHT_SWEEP -- requirements
Module: bht_sweep

Interface
REQ-001 SHALL have parameter NR_ENTRIES, default 128, meaning total 2-bit predictor entries (power of two).
REQ-002 SHALL have parameter INSTR_PER_FETCH, default 2, meaning instruction slots per fetch block (columns per row).
REQ-003 SHALL have parameter VLEN, default 32, meaning virtual PC width.
REQ-004 SHALL have port clk_i  input  1  core clock, with all state updated on its rising edge.
REQ-005 SHALL have port rst_i  input  1  synchronous active-high reset.
REQ-006 SHALL have port flush_bp_i  input  1  clears all predictor state.
REQ-007 SHALL have port debug_mode_i  input  1  suppresses updates while high.
REQ-008 SHALL have port vpc_i  input  VLEN  fetch-block PC for prediction lookup.
REQ-009 SHALL have port update_valid_i  input  1  resolved-branch update strobe.
REQ-010 SHALL have port update_pc_i  input  VLEN  PC of the resolved branch.
REQ-011 SHALL have port update_taken_i  input  1  resolved branch direction.
REQ-012 SHALL have port pred_valid_o  output  INSTR_PER_FETCH  per-slot entry-valid flags.
REQ-013 SHALL have port pred_taken_o  output  INSTR_PER_FETCH  per-slot predicted-taken flags.
REQ-014 SHALL have port ready_o  output  1  high when the array is initialised and usable.

Function
REQ-015 SHALL derive ROWS = NR_ENTRIES/INSTR_PER_FETCH, COL_BITS = log2(INSTR_PER_FETCH), IDX_BITS = log2(ROWS); column = pc[1 +: COL_BITS]; row = pc[1+COL_BITS +: IDX_BITS]; upper PC bits ignored (aliasing allowed).
REQ-016 SHALL store per entry a valid bit and a 2-bit saturating counter; predicted taken = counter[1].
REQ-017 SHALL implement FSM states CLEAR and RUN; CLEAR writes one row per cycle (valid=0, counter=2'b01) via a row pointer from 0 to ROWS-1, then enters RUN.
REQ-018 SHALL assert ready_o only in RUN; pred_valid_o and pred_taken_o SHALL be all-zero in CLEAR.
REQ-019 SHALL read prediction combinationally from the row addressed by vpc_i in RUN (zero-cycle latency).
REQ-020 SHALL, on update_valid_i && !debug_mode_i && RUN, write the addressed entry: if invalid -> valid=1, counter = taken ? 2'b10 : 2'b01; if valid -> increment (taken) or decrement (not taken), saturating at 3 and 0.
REQ-021 SHALL make an update visible to lookups from the following cycle (see REQ-027 for the bypass).
REQ-022 SHALL drop updates arriving in CLEAR or with debug_mode_i high, without side effects.
REQ-023 SHALL, on flush_bp_i in RUN, enter CLEAR with pointer 0 next cycle; flush_bp_i in CLEAR restarts the pointer at 0; a same-cycle update is dropped.

Reset
REQ-024 SHALL, on rst_i, set state=CLEAR and pointer=0; ready_o=0, pred_valid_o=0, pred_taken_o=0 during and after reset until the sweep completes.
REQ-025 SHALL, after rst_i deasserts, assert ready_o exactly ROWS cycles later; rst_i asserted mid-sweep restarts the sweep.
REQ-026 SHALL not require reset of array contents beyond the sweep (array is reset-free storage).

Configuration
REQ-027 SHALL, with macro BHT_UPDATE_BYPASS_EN defined, forward a same-cycle accepted update whose row and column match vpc_i into pred_valid_o/pred_taken_o for that slot; without it, lookups return the pre-update value.

Structure
REQ-028 SHALL place bht_entry_t {valid, counter[1:0]} and the state enum {CLEAR, RUN} in shared package bht_pkg.
REQ-029 SHALL keep the sweep FSM and pointer in sub-module bht_sweep_ctrl (outputs: clear_we, clear_row, ready).

Verification (NR_ENTRIES=128, INSTR_PER_FETCH=2 -> ROWS=64, col=pc[1], row=pc[7:2])
REQ-030 SHALL check reset: rst_i 1 cycle -> ready_o low 64 cycles, high on cycle 64; pred_valid_o=2'b00 throughout.
REQ-031 SHALL check update: taken at 0x8000_0004 -> next cycle vpc_i=0x8000_0004 gives pred_valid_o[0]=1, pred_taken_o[0]=1; two not-taken updates -> taken=0; a third keeps counter 0.
REQ-032 SHALL check saturation/aliasing: 3 taken at 0x8000_0006 (col 1) -> counter 3; one not-taken -> still taken; lookup 0x8000_0106 returns the same entry.
REQ-033 SHALL check flush: flush_bp_i in RUN -> ready_o low next cycle for 64 cycles; updates during sweep dropped; all entries invalid afterwards.
REQ-034 SHALL check debug gating: debug_mode_i=1 with update at 0x8000_0010 -> entry remains invalid.
REQ-035 SHALL check bypass: same-cycle update taken and vpc_i=0x8000_0020 on an invalid entry -> pred_valid_o[0]=1 with BHT_UPDATE_BYPASS_EN, 0 without.
